// File: rtl/zap_mac_seq_unit_pkg.sv
// Shared types, opcode encodings and helpers for the multi-cycle MAC responder.
package zap_mac_seq_unit_pkg;

  localparam int PHY_REGS = 46;
  localparam int ALU_OPS  = 32;
  localparam int OP_W     = $clog2(ALU_OPS);

  // Encodings shared with the shift stage.
  localparam logic [OP_W-1:0] UMLALL = 5'd16;
  localparam logic [OP_W-1:0] UMLALH = 5'd17;
  localparam logic [OP_W-1:0] SMLALL = 5'd18;
  localparam logic [OP_W-1:0] SMLALH = 5'd19;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL0 = 3'd1,
    MUL1 = 3'd2,
    MUL2 = 3'd3,
    MUL3 = 3'd4,
    ACC  = 3'd5,
    DONE = 3'd6
  } mac_state_e;

  function automatic logic is_mac(input logic [OP_W-1:0] op);
    return (op == UMLALL) || (op == UMLALH) || (op == SMLALL) || (op == SMLALH);
  endfunction

  function automatic logic is_signed_op(input logic [OP_W-1:0] op);
    return (op == SMLALL) || (op == SMLALH);
  endfunction

  function automatic logic is_high_op(input logic [OP_W-1:0] op);
    return (op == UMLALH) || (op == SMLALH);
  endfunction

  // 0x80000000 maps to itself, which is the correct unsigned magnitude 2^31.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

  function automatic logic [31:0] sel_word(input logic [63:0] r, input logic hi);
    return hi ? r[63:32] : r[31:0];
  endfunction

endpackage

// File: rtl/zap_mac_pp16.sv
// Combinational 16x16 -> 32 unsigned partial product, time-shared by the MAC FSM.
module zap_mac_pp16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  assign p = {16'd0, a} * {16'd0, b};

endmodule

// File: rtl/zap_mac_seq_unit.sv
// Multi-cycle 32x32+64 UMLAL/SMLAL responder with a one-entry result cache so the
// paired half-op of a long multiply returns with zero latency.
module zap_mac_seq_unit
  import zap_mac_seq_unit_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_data_stall,
  input  logic            i_clear_from_writeback,
  input  logic            i_clear_from_alu,
  input  logic [OP_W-1:0] i_alu_operation_ff,
  input  logic            i_cc_satisfied,
  input  logic [31:0]     i_rm,
  input  logic [31:0]     i_rs,
  input  logic [31:0]     i_rh,
  input  logic [31:0]     i_rn,
  output logic [31:0]     o_rd,
  output logic            o_busy
);

  mac_state_e   state_r;
  logic [31:0]  mag_a_r, mag_b_r;
  logic         neg_r, hi_r, cache_valid_r;
  logic [63:0]  prod_r, cache_r;
  // Tag layout {sgn, rm, rs, rh, rn}; the low 64 bits double as the accumulator.
  logic [128:0] lat_tag_r, cached_tag_r;

  logic         mac_req_s, sgn_s, hi_s, hit_s, miss_s;
  logic [128:0] tag_s;
  logic [15:0]  pp_a_s, pp_b_s;
  logic [31:0]  pp_s;
  logic [63:0]  pp_term_s, result_s;

  assign mac_req_s = is_mac(i_alu_operation_ff) & i_cc_satisfied;
  assign sgn_s     = is_signed_op(i_alu_operation_ff);
  assign hi_s      = is_high_op(i_alu_operation_ff);
  assign tag_s     = {sgn_s, i_rm, i_rs, i_rh, i_rn};
  assign hit_s     = mac_req_s & cache_valid_r & (tag_s == cached_tag_r) & (state_r == IDLE);
  assign miss_s    = mac_req_s & ~hit_s & (state_r == IDLE);
  assign result_s  = (neg_r ? (64'd0 - prod_r) : prod_r) + lat_tag_r[63:0];

  zap_mac_pp16 u_pp16 (
    .a (pp_a_s),
    .b (pp_b_s),
    .p (pp_s)
  );

  // Select the magnitude halves and weight for the current partial-product step.
  always_comb begin
    pp_a_s    = mag_a_r[15:0];
    pp_b_s    = mag_b_r[15:0];
    pp_term_s = {32'd0, pp_s};
    case (state_r)
      MUL1: begin
        pp_a_s    = mag_a_r[31:16];
        pp_term_s = {16'd0, pp_s, 16'd0};
      end
      MUL2: begin
        pp_b_s    = mag_b_r[31:16];
        pp_term_s = {16'd0, pp_s, 16'd0};
      end
      MUL3: begin
        pp_a_s    = mag_a_r[31:16];
        pp_b_s    = mag_b_r[31:16];
        pp_term_s = {pp_s, 32'd0};
      end
      default: begin
        pp_term_s = {32'd0, pp_s};
      end
    endcase
  end

  // Stall request and result word, derived from state and the presented op.
  always_comb begin
    o_busy = 1'b0;
    o_rd   = 32'd0;
    if (i_reset) begin
      o_busy = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (hit_s) begin
            o_rd = sel_word(cache_r, hi_s);
          end else begin
            o_busy = mac_req_s;
          end
        end
        MUL0, MUL1, MUL2, MUL3, ACC: o_busy = 1'b1;
        DONE: o_rd = mac_req_s ? sel_word(cache_r, hi_r) : 32'd0;
        default: o_busy = 1'b0;
      endcase
    end
  end

  // Control priority: reset, writeback clear, data stall hold, ALU clear, then the FSM.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r       <= IDLE;
      cache_valid_r <= 1'b0;
      cache_r       <= 64'd0;
      prod_r        <= 64'd0;
      cached_tag_r  <= 129'd0;
      lat_tag_r     <= 129'd0;
      mag_a_r       <= 32'd0;
      mag_b_r       <= 32'd0;
      neg_r         <= 1'b0;
      hi_r          <= 1'b0;
    end else if (i_clear_from_writeback) begin
      state_r       <= IDLE;
      cache_valid_r <= 1'b0;
    end else if (i_data_stall) begin
      state_r       <= state_r;
    end else if (i_clear_from_alu) begin
      state_r       <= IDLE;
      cache_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (miss_s) begin
            lat_tag_r <= tag_s;
            mag_a_r   <= mag32(i_rm, sgn_s);
            mag_b_r   <= mag32(i_rs, sgn_s);
            neg_r     <= sgn_s & (i_rm[31] ^ i_rs[31]);
            hi_r      <= hi_s;
            prod_r    <= 64'd0;
            state_r   <= MUL0;
          end
        end
        MUL0: begin
          prod_r  <= prod_r + pp_term_s;
          state_r <= MUL1;
        end
        MUL1: begin
          prod_r  <= prod_r + pp_term_s;
          state_r <= MUL2;
        end
        MUL2: begin
          prod_r  <= prod_r + pp_term_s;
          state_r <= MUL3;
        end
        MUL3: begin
          prod_r  <= prod_r + pp_term_s;
          state_r <= ACC;
        end
        ACC: begin
          cache_r       <= result_s;
          cached_tag_r  <= lat_tag_r;
          cache_valid_r <= 1'b1;
          state_r       <= DONE;
        end
        DONE: state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zap_mac_seq_unit.sv
// Directed plus random bench for zap_mac_seq_unit against a 64-bit arithmetic reference.
module tb_zap_mac_seq_unit;
  import zap_mac_seq_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, data_stall, clr_wb, clr_alu, cc;
  logic [4:0]  op;
  logic [31:0] rm, rs, rh, rn, rd;
  logic        busy;
  int          errors = 0;
  int          checks = 0;
  // Reference cache: last fully completed operation.
  logic        m_valid = 1'b0;
  logic [128:0] m_tag = '0;

  always #5 clk = ~clk;

  zap_mac_seq_unit dut (
    .i_clk                  (clk),
    .i_reset                (reset),
    .i_data_stall           (data_stall),
    .i_clear_from_writeback (clr_wb),
    .i_clear_from_alu       (clr_alu),
    .i_alu_operation_ff     (op),
    .i_cc_satisfied         (cc),
    .i_rm                   (rm),
    .i_rs                   (rs),
    .i_rh                   (rh),
    .i_rn                   (rn),
    .o_rd                   (rd),
    .o_busy                 (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mac(input logic sgn, input logic [31:0] a, b, h, l);
    longint p;
    if (sgn) p = longint'($signed(a)) * longint'($signed(b));
    else     p = longint'({32'd0, a}) * longint'({32'd0, b});
    return 64'(p) + {h, l};
  endfunction

  // Present one op and run until o_busy drops. kind: 0 none, 1 alu clear, 2 wb clear.
  // Stall window [st_c, st_c+st_n); clear pulse at cycle cl_c; extra = expected added cycles.
  task automatic do_op(input string tag, input logic [4:0] o, input logic [31:0] a, b, h, l,
                       input int st_c, input int st_n, input int kind, input int cl_c,
                       input int extra);
    logic        sgn, hi;
    logic [63:0] r;
    int          exp_lat, cyc;
    sgn = (o == SMLALL) || (o == SMLALH);
    hi  = (o == UMLALH) || (o == SMLALH);
    r   = ref_mac(sgn, a, b, h, l);
    exp_lat = (m_valid && m_tag == {sgn, a, b, h, l}) ? 0 : 6 + extra;
    @(negedge clk);
    op = o; cc = 1'b1; rm = a; rs = b; rh = h; rn = l;
    data_stall = 1'b0; clr_alu = 1'b0; clr_wb = 1'b0;
    cyc = 0;
    #1;
    while (busy === 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      data_stall = (cyc >= st_c) && (cyc < st_c + st_n);
      clr_alu    = (kind == 1) && (cyc == cl_c);
      clr_wb     = (kind == 2) && (cyc == cl_c);
      #1;
    end
    data_stall = 1'b0; clr_alu = 1'b0; clr_wb = 1'b0;
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_rd"}, 64'(rd), 64'(hi ? r[63:32] : r[31:0]));
    m_valid = 1'b1;
    m_tag   = {sgn, a, b, h, l};
  endtask

  initial begin
    logic [4:0]  ro;
    logic [31:0] ra, rb, rhh, rl;
    reset = 1'b1; data_stall = 1'b0; clr_wb = 1'b0; clr_alu = 1'b0;
    op = UMLALL; cc = 1'b1; rm = 32'hFFFF_FFFF; rs = 32'hFFFF_FFFF; rh = 32'd0; rn = 32'd1;
    @(negedge clk); #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_rd", 64'(rd), 64'd0);
    @(negedge clk);
    reset = 1'b0; op = 5'd0;
    #1;
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_rd", 64'(rd), 64'd0);

    // Full miss then zero-latency paired half.
    do_op("t1_lo", UMLALL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 0, 0, 0, 0, 0);
    do_op("t1_hi", UMLALH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 0, 0, 0, 0, 0);
    do_op("t2_neg", SMLALH, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd5, 0, 0, 0, 0, 0);
    do_op("t2_min", SMLALL, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 0, 0, 0, 0, 0);
    do_op("t2_minh", SMLALH, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 0, 0, 0, 0, 0);

    // Condition fail: no stall, no output, cache untouched.
    @(negedge clk);
    op = UMLALL; cc = 1'b0; rm = 32'h1234; rs = 32'h5678; rh = 32'd0; rn = 32'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_busy", 64'(busy), 64'd0);
      check("t3_rd", 64'(rd), 64'd0);
      @(negedge clk);
    end
    do_op("t3_cache", SMLALL, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 0, 0, 0, 0, 0);

    // Clears and stalls.
    do_op("t4_clralu", UMLALL, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h1, 32'h2, 0, 0, 1, 3, 4);
    do_op("t5_stall", SMLALH, 32'hCAFE_0001, 32'h7FFF_FFFF, 32'h9, 32'hFFFF_FFFF, 2, 3, 0, 0, 3);
    do_op("t5_stalu", UMLALH, 32'h0001_0001, 32'hFFFF_0000, 32'h3, 32'h4, 3, 1, 1, 3, 1);
    do_op("t5_stwb", SMLALL, 32'h8765_4321, 32'h1357_9BDF, 32'h5, 32'h6, 3, 1, 2, 3, 4);

    // Reset during ACC.
    do_op("t6_pre", UMLALL, 32'h11, 32'h22, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    op = SMLALL; cc = 1'b1; rm = 32'hF00F_F00F; rs = 32'h0FF0_0FF0; rh = 32'd0; rn = 32'd0;
    for (int i = 1; i <= 5; i++) @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_rd", 64'(rd), 64'd0);
    @(negedge clk);
    reset = 1'b0; op = 5'd0;
    m_valid = 1'b0;
    do_op("t6_after", UMLALH, 32'h11, 32'h22, 32'h0, 32'h0, 0, 0, 0, 0, 0);

    // Random scoreboard, sometimes re-presenting the paired half.
    ro = UMLALL; ra = 32'd0; rb = 32'd0; rhh = 32'd0; rl = 32'd0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0 && $urandom_range(0, 2) == 0) begin
        ro = ro ^ 5'd1;
      end else begin
        ro  = UMLALL + 5'($urandom_range(0, 3));
        ra  = $urandom; rb = $urandom; rhh = $urandom; rl = $urandom;
        if ($urandom_range(0, 4) == 0) ra = 32'h8000_0000;
      end
      do_op("rnd", ro, ra, rb, rhh, rl, 0, 0, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
